// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: start/done handshake, goto table,
// conditional backward branch and a saturating run-cycle counter.
module fetch_sequencer #(
    parameter int PC_W  = 10,
    parameter int LUT_N = 8,
    parameter int CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Ack,
    input  logic                     GotoEn,
    input  logic                     Jump2En,
    input  logic                     Zero,
    input  logic [$clog2(LUT_N)-1:0] TargIdx,
    input  logic [5:0]               LoopOff,
    input  logic                     LutWrEn,
    input  logic [$clog2(LUT_N)-1:0] LutWrIdx,
    input  logic [PC_W-1:0]          LutWrData,
    output logic [PC_W-1:0]          ProgCtr,
    output logic                     Running,
    output logic                     Done,
    output logic [CNT_W-1:0]         CycleCount
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_start_q;
    logic              w_start_rise;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_running, r_done;
    logic [PC_W-1:0]   r_lut [LUT_N];

    assign w_start_rise = Start & ~r_start_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= Start;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            // Decoded from the next state so the flags line up with the state register
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_rise) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_cnt != '1)
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                // Ack keeps the terminating instruction address visible
                if (Ack)
                    w_state_nxt = S_DONE;
                else if (GotoEn)
                    w_pc_nxt = r_lut[TargIdx];
                else if (Jump2En && !Zero)
                    w_pc_nxt = r_pc - PC_W'(LoopOff);
                else
                    w_pc_nxt = r_pc + PC_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Goto reads the registered contents, so a same-cycle write is seen one cycle later
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++)
                r_lut[i] <= '0;
        end else if (LutWrEn) begin
            r_lut[LutWrIdx] <= LutWrData;
        end
    end

    assign ProgCtr    = r_pc;
    assign Running    = r_running;
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded random/directed bench for fetch_sequencer against a
// behavioural model of the program-counter rules.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0, Ack = 1'b0, GotoEn = 1'b0, Jump2En = 1'b0, Zero = 1'b0;
    logic [2:0]  TargIdx = '0, LutWrIdx = '0;
    logic [5:0]  LoopOff = '0;
    logic        LutWrEn = 1'b0;
    logic [9:0]  LutWrData = '0;
    logic [9:0]  ProgCtr;
    logic        Running, Done;
    logic [15:0] CycleCount;

    fetch_sequencer #(.PC_W(10), .LUT_N(8), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .GotoEn(GotoEn),
        .Jump2En(Jump2En), .Zero(Zero), .TargIdx(TargIdx), .LoopOff(LoopOff),
        .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx), .LutWrData(LutWrData),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    nvec = 0;
    int    nerr = 0;

    // behavioural model
    int  m_pc, m_cnt;
    bit  m_run, m_done, m_sq;
    int  m_tab [8];

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_sq = 0;
        for (int i = 0; i < 8; i++) m_tab[i] = 0;
    endtask

    task automatic step(input bit st, input bit ack, input bit go, input bit j2, input bit z,
                        input bit [2:0] ti, input bit [5:0] lo,
                        input bit we, input bit [2:0] wi, input bit [9:0] wd, input string tag);
        bit rise;
        @(negedge Clk);
        Start = st; Ack = ack; GotoEn = go; Jump2En = j2; Zero = z;
        TargIdx = ti; LoopOff = lo; LutWrEn = we; LutWrIdx = wi; LutWrData = wd;
        rise = st && !m_sq;
        m_sq = st;
        if (m_run) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (ack)            begin m_run = 0; m_done = 1; end
            else if (go)        m_pc = m_tab[ti];
            else if (j2 && !z)  m_pc = (m_pc + 1024 - int'(lo)) % 1024;
            else                m_pc = (m_pc + 1) % 1024;
        end else if (rise) begin
            m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
        end
        if (we) m_tab[wi] = int'(wd);
        q.push_back('{pc: 10'(m_pc), run: m_run, done: m_done, cnt: 16'(m_cnt)});
        tq.push_back(tag);
    endtask

    task automatic nop(input bit st, input string tag);
        step(st, 0, 0, 0, 0, 3'd0, 6'd0, 0, 3'd0, 10'd0, tag);
    endtask

    task automatic goto_idx(input bit [2:0] idx, input string tag);
        step(1, 0, 1, 0, 0, idx, 6'd0, 0, 3'd0, 10'd0, tag);
    endtask

    task automatic wr(input bit st, input bit [2:0] idx, input bit [9:0] d, input string tag);
        step(st, 0, 0, 0, 0, 3'd0, 6'd0, 1, idx, d, tag);
    endtask

    task automatic ensure_run();
        if (!m_run) begin
            nop(0, "drop_start");
            nop(1, "raise_start");
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // monitor: one expectation per clock edge
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                t = tq.pop_front();
                nvec++;
                if (ProgCtr !== e.pc || Running !== e.run || Done !== e.done || CycleCount !== e.cnt) begin
                    nerr++;
                    $display("FAIL %s: pc=%h run=%b done=%b cnt=%h, expected pc=%h run=%b done=%b cnt=%h",
                             t, ProgCtr, Running, Done, CycleCount, e.pc, e.run, e.done, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge Clk);
        chk("reset_pc", int'(ProgCtr), 0);
        chk("reset_run", int'(Running), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_cnt", int'(CycleCount), 0);
        Reset = 1'b1;

        // start and goto table
        wr(0, 3'd5, 10'h1A0, "idle_wr5");
        nop(1, "start");
        nop(1, "inc1");
        nop(1, "inc2");
        nop(1, "inc3");
        goto_idx(3'd5, "goto_1a0");
        step(1, 0, 1, 0, 0, 3'd5, 6'd0, 1, 3'd5, 10'h050, "goto_same_cycle_wr");
        goto_idx(3'd5, "goto_050");

        // loop branch
        wr(1, 3'd1, 10'h020, "wr1");
        goto_idx(3'd1, "goto_020");
        step(1, 0, 0, 1, 0, 3'd0, 6'd4, 0, 3'd0, 10'd0, "loop_taken");
        goto_idx(3'd1, "goto_020b");
        step(1, 0, 0, 1, 1, 3'd0, 6'd4, 0, 3'd0, 10'd0, "loop_zero");
        wr(1, 3'd2, 10'h002, "wr2");
        goto_idx(3'd2, "goto_002");
        step(1, 0, 0, 1, 0, 3'd0, 6'd5, 0, 3'd0, 10'd0, "loop_wrap");
        nop(1, "inc_3fe");
        nop(1, "inc_3ff");
        nop(1, "inc_wrap0");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit st;
            st = ($urandom_range(0, 15) == 0) ? !m_sq : m_sq;
            if (!m_run && !m_done) st = 1;
            step(st, $urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0, 1'($urandom), 3'($urandom), 6'($urandom),
                 $urandom_range(0, 3) == 0, 3'($urandom), 10'($urandom), "random");
        end

        // priority and done
        ensure_run();
        wr(1, 3'd3, 10'h044, "wr3");
        goto_idx(3'd3, "goto_044");
        step(1, 1, 1, 1, 0, 3'd3, 6'd1, 0, 3'd0, 10'd0, "prio_ack");
        for (int i = 0; i < 3; i++)
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                 6'($urandom), 0, 3'd0, 10'd0, "done_frozen");
        nop(0, "drop");
        nop(1, "restart");

        // counter saturation via spin loop
        for (int i = 0; i < 65540; i++)
            step(1, 0, 0, 1, 0, 3'd0, 6'd0, 0, 3'd0, 10'd0, "spin_sat");
        @(negedge Clk);
        chk("cnt_saturated", int'(CycleCount), 16'hFFFF);

        // async reset mid-run
        wr(1, 3'd4, 10'h010, "wr4");
        goto_idx(3'd4, "goto_010");
        @(posedge Clk);
        #3;
        Start = 1'b0;
        Reset = 1'b0;
        #1;
        chk("async_rst_pc", int'(ProgCtr), 0);
        chk("async_rst_run", int'(Running), 0);
        chk("async_rst_cnt", int'(CycleCount), 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        nop(0, "idle_after_rst");
        step(0, 1, 1, 1, 0, 3'd4, 6'd3, 0, 3'd0, 10'd0, "idle_ignores_flow");
        nop(0, "idle_after_rst2");
        nop(1, "start_after_rst");
        goto_idx(3'd4, "tab_cleared4");
        goto_idx(3'd5, "tab_cleared5");
        nop(1, "tail");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        #2;
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
